// File: rtl/bpred_pkg.sv
// Shared types, constants and arithmetic helpers for the perceptron
// branch-predictor history controller.
package bpred_pkg;

   localparam int GHR_DEPTH  = 20;
   localparam int TABLE_SIZE = 228;
   localparam int HIST_LEN   = 8;
   localparam int WEIGHT_W   = 8;
   localparam int PUSH_MAX   = 4;
   localparam int ENTRY_W    = 33;
   localparam int ROW_W      = (HIST_LEN + 1) * WEIGHT_W;
   localparam int PTR_W      = 5;
   localparam int CNT_W      = 5;

   localparam logic signed [WEIGHT_W:0] W_MAX = 9'sd127;
   localparam logic signed [WEIGHT_W:0] W_MIN = -9'sd128;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
   } ghr_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WAIT = 2'd2,
      ST_WR   = 2'd3
   } train_state_t;

   // Adds +1 or -1 to a signed weight, clamping at the representable range.
   function automatic logic [WEIGHT_W-1:0] sat_add(input logic [WEIGHT_W-1:0] w,
                                                   input logic                up);
      logic signed [WEIGHT_W:0] sum;
      sum = $signed({w[WEIGHT_W-1], w}) + (up ? 9'sd1 : -9'sd1);
      if (sum > W_MAX) begin
         return 8'h7F;
      end else if (sum < W_MIN) begin
         return 8'h80;
      end else begin
         return sum[WEIGHT_W-1:0];
      end
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                input logic [2:0]       add);
      logic [5:0] s;
      s = 6'(ptr) + 6'(add);
      return (s >= 6'(GHR_DEPTH)) ? PTR_W'(s - 6'(GHR_DEPTH)) : PTR_W'(s);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] ptr,
                                                input logic [3:0]       off);
      logic [5:0] s;
      s = 6'(ptr) + 6'(GHR_DEPTH) - 6'(off);
      return (s >= 6'(GHR_DEPTH)) ? PTR_W'(s - 6'(GHR_DEPTH)) : PTR_W'(s);
   endfunction

endpackage

// File: rtl/bpred_history_ctrl_if.sv
// Predictor push, backend resolve, weight-RAM and status signals of the
// history controller, grouped with a master (environment) and slave (controller) view.
interface bpred_history_ctrl_if
   import bpred_pkg::*;
();

   logic                        i_push_valid;
   logic [2:0]                  i_push_num;
   logic [PUSH_MAX*ENTRY_W-1:0] i_push_entries;
   logic                        o_push_ready;

   logic                        i_resolve_valid;
   logic                        i_resolve_taken;
   logic [31:0]                 i_resolve_target;
   logic                        o_resolve_ready;

   logic                        o_wt_rd_en;
   logic [7:0]                  o_wt_rd_idx;
   logic [ROW_W-1:0]            i_wt_rd_data;
   logic                        o_wt_wr_en;
   logic [7:0]                  o_wt_wr_idx;
   logic [ROW_W-1:0]            o_wt_wr_data;

   logic                        o_flush;
   logic [31:0]                 o_flush_pc;
   logic [HIST_LEN-1:0]         o_spec_hist;
   logic [CNT_W-1:0]            o_pending_cnt;
   logic                        o_train_busy;

   modport slave (
      input  i_push_valid, i_push_num, i_push_entries,
      input  i_resolve_valid, i_resolve_taken, i_resolve_target,
      input  i_wt_rd_data,
      output o_push_ready, o_resolve_ready,
      output o_wt_rd_en, o_wt_rd_idx, o_wt_wr_en, o_wt_wr_idx, o_wt_wr_data,
      output o_flush, o_flush_pc, o_spec_hist, o_pending_cnt, o_train_busy
   );

   modport master (
      output i_push_valid, i_push_num, i_push_entries,
      output i_resolve_valid, i_resolve_taken, i_resolve_target,
      output i_wt_rd_data,
      input  o_push_ready, o_resolve_ready,
      input  o_wt_rd_en, o_wt_rd_idx, o_wt_wr_en, o_wt_wr_idx, o_wt_wr_data,
      input  o_flush, o_flush_pc, o_spec_hist, o_pending_cnt, o_train_busy
   );

endinterface

// File: rtl/bpred_weight_update.sv
// Perceptron row update: each history weight moves toward agreement with the
// actual outcome, the bias moves toward the outcome, all with saturation.
module bpred_weight_update
   import bpred_pkg::*;
(
   input  logic [ROW_W-1:0]    row_in,
   input  logic [HIST_LEN-1:0] hist,
   input  logic                correct,
   output logic [ROW_W-1:0]    row_out
);

   // Per-weight saturating increment/decrement; bias occupies the top slot.
   always_comb begin
      row_out = {ROW_W{1'b0}};
      for (int j = 0; j < HIST_LEN; j++) begin
         row_out[j*WEIGHT_W +: WEIGHT_W] = sat_add(row_in[j*WEIGHT_W +: WEIGHT_W],
                                                   hist[j] == correct);
      end
      row_out[HIST_LEN*WEIGHT_W +: WEIGHT_W] = sat_add(row_in[HIST_LEN*WEIGHT_W +: WEIGHT_W],
                                                       correct);
   end

endmodule

// File: rtl/bpred_history_ctrl.sv
// Speculative branch buffer, committed history and mispredict-driven
// read-modify-write training of one weight row, with fetch flush.
module bpred_history_ctrl
   import bpred_pkg::*;
(
   input logic                 i_clk,
   input logic                 i_rst_n,
   bpred_history_ctrl_if.slave bus
);

   ghr_entry_t          ghr_r [GHR_DEPTH];
   logic [PTR_W-1:0]    head_r;
   logic [PTR_W-1:0]    tail_r;
   logic [CNT_W-1:0]    count_r;
   logic [HIST_LEN-1:0] commit_hist_r;

   train_state_t        state_r;
   train_state_t        state_nx;
   logic [7:0]          idx_r;
   logic [HIST_LEN-1:0] train_hist_r;
   logic                correct_r;
   logic [ROW_W-1:0]    wr_row_r;
   logic                flush_r;
   logic [31:0]         flush_pc_r;

   logic                idle_s;
   logic                push_ready_s;
   logic                resolve_ready_s;
   logic                push_num_ok_s;
   logic                push_fire_s;
   logic                resolve_fire_s;
   logic                mispredict_s;
   ghr_entry_t          head_ent_s;
   logic [2:0]          push_add_s;
   logic [7:0]          head_idx_s;
   logic [HIST_LEN-1:0] spec_hist_s;
   logic [ROW_W-1:0]    upd_row_s;

   // Handshake qualification and mispredict detection on the oldest entry.
   always_comb begin
      idle_s          = (state_r == ST_IDLE);
      push_ready_s    = idle_s && (count_r <= CNT_W'(GHR_DEPTH - PUSH_MAX));
      resolve_ready_s = idle_s && (count_r != 5'd0);
      push_num_ok_s   = (bus.i_push_num != 3'd0) && (bus.i_push_num <= 3'(PUSH_MAX));
      push_fire_s     = bus.i_push_valid && push_ready_s && push_num_ok_s;
      resolve_fire_s  = bus.i_resolve_valid && resolve_ready_s;
      head_ent_s      = ghr_r[head_r];
      mispredict_s    = resolve_fire_s && (head_ent_s.taken != bus.i_resolve_taken);
      push_add_s      = push_fire_s ? bus.i_push_num : 3'd0;
      head_idx_s      = 8'(head_ent_s.pc % 32'(TABLE_SIZE));
   end

   // Circular buffer, pointers, occupancy and committed history.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < GHR_DEPTH; i++) begin
            ghr_r[i] <= {ENTRY_W{1'b0}};
         end
         head_r        <= 5'd0;
         tail_r        <= 5'd0;
         count_r       <= 5'd0;
         commit_hist_r <= 8'd0;
      end else begin
         if (push_fire_s && !mispredict_s) begin
            for (int k = 0; k < PUSH_MAX; k++) begin
               if (3'(k) < bus.i_push_num) begin
                  ghr_r[ptr_inc(tail_r, 3'(k))] <=
                     ghr_entry_t'(bus.i_push_entries[k*ENTRY_W +: ENTRY_W]);
               end
            end
         end
         // A mispredict discards every younger speculative entry, including any pushed now.
         if (mispredict_s) begin
            tail_r  <= ptr_inc(head_r, 3'd1);
            count_r <= 5'd0;
         end else begin
            tail_r  <= ptr_inc(tail_r, push_add_s);
            count_r <= count_r + CNT_W'(push_add_s) - CNT_W'(resolve_fire_s);
         end
         if (resolve_fire_s) begin
            head_r        <= ptr_inc(head_r, 3'd1);
            commit_hist_r <= {commit_hist_r[HIST_LEN-2:0], bus.i_resolve_taken};
         end
      end
   end

   // Speculative history: youngest in-flight predictions, then committed outcomes.
   always_comb begin
      spec_hist_s = 8'd0;
      for (int i = 0; i < HIST_LEN; i++) begin
         if (CNT_W'(i) < count_r) begin
            spec_hist_s[i] = ghr_r[ptr_dec(tail_r, 4'(i + 1))].taken;
         end else begin
            spec_hist_s[i] = commit_hist_r[3'(CNT_W'(i) - count_r)];
         end
      end
   end

   // Training FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Training FSM next state: one cycle each for read, data return and write.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (mispredict_s) begin
               state_nx = ST_RD;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_RD:   state_nx = ST_WAIT;
         ST_WAIT: state_nx = ST_WR;
         ST_WR:   state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   bpred_weight_update u_weight_update (
      .row_in  (bus.i_wt_rd_data),
      .hist    (train_hist_r),
      .correct (correct_r),
      .row_out (upd_row_s)
   );

   // Training context captured at the mispredict; updated row registered as data returns.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx_r        <= 8'd0;
         train_hist_r <= 8'd0;
         correct_r    <= 1'b0;
         wr_row_r     <= {ROW_W{1'b0}};
      end else begin
         if (mispredict_s) begin
            idx_r        <= head_idx_s;
            train_hist_r <= commit_hist_r;
            correct_r    <= bus.i_resolve_taken;
         end
         if (state_r == ST_WAIT) begin
            wr_row_r <= upd_row_s;
         end
      end
   end

   // One-cycle fetch redirect following a mispredicted resolve.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         flush_r    <= 1'b0;
         flush_pc_r <= 32'd0;
      end else begin
         flush_r    <= mispredict_s;
         flush_pc_r <= mispredict_s ? bus.i_resolve_target : 32'd0;
      end
   end

   assign bus.o_push_ready    = push_ready_s;
   assign bus.o_resolve_ready = resolve_ready_s;
   assign bus.o_wt_rd_en      = (state_r == ST_RD);
   assign bus.o_wt_rd_idx     = (state_r == ST_RD) ? idx_r : 8'd0;
   assign bus.o_wt_wr_en      = (state_r == ST_WR);
   assign bus.o_wt_wr_idx     = (state_r == ST_WR) ? idx_r : 8'd0;
   assign bus.o_wt_wr_data    = (state_r == ST_WR) ? wr_row_r : {ROW_W{1'b0}};
   assign bus.o_flush         = flush_r;
   assign bus.o_flush_pc      = flush_pc_r;
   assign bus.o_spec_hist     = spec_hist_s;
   assign bus.o_pending_cnt   = count_r;
   assign bus.o_train_busy    = (state_r != ST_IDLE);

endmodule
